// File: rtl/sap_pkg.sv
`timescale 1ns/1ps
// sap_pkg: shared state encoding and default widths for the SAP front-panel RAM loader.
package sap_pkg;

    localparam int DEF_ADDR_W     = 4;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_CLR_CYCLES = 2;
    localparam int DEF_WR_CYCLES  = 2;

    // Loader sequence: clear the core, then per address wait for a byte,
    // set up address/data, strobe the write, hold, and finally request a run.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SETUP  = 3'd3,
        ST_STROBE = 3'd4,
        ST_HOLD   = 3'd5,
        ST_FINISH = 3'd6
    } load_state_t;

    // Larger of two integers, used to size the shared cycle counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ram_loader.sv
`timescale 1ns/1ps
// ram_loader: streams program bytes from a valid/ready source into the SAP
// core RAM through its front-panel clear/prog/write strobes, one address at a
// time, then pulses run_req. A single counter times both the clear strobe and
// the write strobe since those phases never overlap.
module ram_loader
    import sap_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int CLR_CYCLES = DEF_CLR_CYCLES,
    parameter int WR_CYCLES  = DEF_WR_CYCLES
) (
    input  logic              sysclk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              fp_clear,
    output logic              fp_prog,
    output logic              fp_write,
    output logic [ADDR_W-1:0] fp_adr,
    output logic [DATA_W-1:0] fp_data,
    output logic              run_req,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(max_int(CLR_CYCLES, WR_CYCLES) + 1);
    localparam logic [ADDR_W-1:0] LAST_ADR = {ADDR_W{1'b1}};

    load_state_t      state_reg;
    logic [CNT_W-1:0] cnt_reg;

    // Only the WAIT state takes a byte, so at most one byte lands per address.
    assign in_ready = (state_reg == ST_WAIT);

    // Loader sequencer: state, shared cycle counter, address/data and all registered strobes.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            fp_clear  <= 1'b0;
            fp_prog   <= 1'b0;
            fp_write  <= 1'b0;
            fp_adr    <= '0;
            fp_data   <= '0;
            run_req   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (abort && (state_reg != ST_IDLE)) begin
            // Cancel wins over everything; any byte offered this cycle is dropped
            // and the outputs return to their reset values.
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            fp_clear  <= 1'b0;
            fp_prog   <= 1'b0;
            fp_write  <= 1'b0;
            fp_adr    <= '0;
            fp_data   <= '0;
            run_req   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            run_req <= 1'b0;
            unique case (state_reg)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state_reg <= ST_CLEAR;
                        cnt_reg   <= CNT_W'(CLR_CYCLES - 1);
                        fp_adr    <= '0;
                        done      <= 1'b0;
                        fp_clear  <= 1'b1;
                        fp_prog   <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (cnt_reg == '0) begin
                        state_reg <= ST_WAIT;
                        fp_clear  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    // in_ready is high here, so in_valid alone completes the handshake.
                    if (in_valid) begin
                        fp_data   <= in_data;
                        state_reg <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    state_reg <= ST_STROBE;
                    fp_write  <= 1'b1;
                    cnt_reg   <= CNT_W'(WR_CYCLES - 1);
                end
                ST_STROBE: begin
                    if (cnt_reg == '0) begin
                        fp_write  <= 1'b0;
                        state_reg <= ST_HOLD;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    // The last address ends the load instead of wrapping to zero.
                    if (fp_adr == LAST_ADR) begin
                        state_reg <= ST_FINISH;
                        fp_prog   <= 1'b0;
                        run_req   <= 1'b1;
                        done      <= 1'b1;
                    end else begin
                        fp_adr    <= fp_adr + ADDR_W'(1);
                        state_reg <= ST_WAIT;
                    end
                end
                ST_FINISH: begin
                    state_reg <= ST_IDLE;
                    busy      <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    fp_clear  <= 1'b0;
                    fp_prog   <= 1'b0;
                    fp_write  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_loader.sv
`timescale 1ns/1ps
// tb_ram_loader: cycle table for the opening of a load, then full, randomized,
// aborted and reset-interrupted loads checked against a byte-queue model.
module tb_ram_loader;

    localparam int ADDR_W     = 4;
    localparam int DATA_W     = 8;
    localparam int CLR_CYCLES = 2;
    localparam int WR_CYCLES  = 2;
    localparam int DEPTH      = 1 << ADDR_W;
    localparam int STAB_SPAN  = 2 + WR_CYCLES;   // SETUP + STROBE cycles + HOLD

    logic              sysclk   = 1'b0;
    logic              reset_n  = 1'b0;
    logic              start    = 1'b0;
    logic              abort    = 1'b0;
    logic [DATA_W-1:0] in_data  = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              fp_clear;
    logic              fp_prog;
    logic              fp_write;
    logic [ADDR_W-1:0] fp_adr;
    logic [DATA_W-1:0] fp_data;
    logic              run_req;
    logic              busy;
    logic              done;

    ram_loader #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .CLR_CYCLES(CLR_CYCLES),
        .WR_CYCLES (WR_CYCLES)
    ) dut (
        .sysclk  (sysclk),
        .reset_n (reset_n),
        .start   (start),
        .abort   (abort),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .fp_clear(fp_clear),
        .fp_prog (fp_prog),
        .fp_write(fp_write),
        .fp_adr  (fp_adr),
        .fp_data (fp_data),
        .run_req (run_req),
        .busy    (busy),
        .done    (done)
    );

    always #5 sysclk = ~sysclk;

    // Output vector order: busy, in_ready, fp_clear, fp_prog, fp_write, run_req, done, fp_adr, fp_data
    typedef struct {
        logic              start;
        logic              abort;
        logic              in_valid;
        logic [DATA_W-1:0] in_data;
        logic [18:0]       exp;
    } vec_t;

    vec_t vecs[12];

    int checks   = 0;
    int failures = 0;

    // Model state: bytes accepted by handshake, and write pulses observed on the RAM port.
    logic [DATA_W-1:0] acc_q[$];
    logic [ADDR_W-1:0] wr_adr_q[$];
    logic [DATA_W-1:0] wr_data_q[$];
    int                wr_width;
    int                clr_width;
    int                run_cnt;
    int                stab_cnt;
    bit                prev_write;
    bit                prev_clear;
    logic [ADDR_W-1:0] snap_adr;
    logic [DATA_W-1:0] snap_data;

    function automatic logic [18:0] outs();
        return {busy, in_ready, fp_clear, fp_prog, fp_write, run_req, done, fp_adr, fp_data};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic mon_clear();
        acc_q.delete();
        wr_adr_q.delete();
        wr_data_q.delete();
        wr_width   = 0;
        clr_width  = 0;
        run_cnt    = 0;
        stab_cnt   = 0;
        prev_write = 1'b0;
        prev_clear = 1'b0;
    endtask

    // One clock: note any handshake, step the edge, then observe the outputs 1 ns later.
    task automatic tick();
        bit                acc;
        logic [DATA_W-1:0] acc_byte;
        acc      = reset_n && in_valid && in_ready && !abort;
        acc_byte = in_data;
        @(posedge sysclk);
        #1;
        if (acc) begin
            acc_q.push_back(acc_byte);
            stab_cnt = STAB_SPAN;
        end
        if (stab_cnt > 0) begin
            if (stab_cnt == STAB_SPAN) begin
                snap_adr  = fp_adr;
                snap_data = fp_data;
                check("setup_adr_data", 32'({fp_adr, fp_data}),
                      32'({ADDR_W'(acc_q.size() - 1), acc_byte}));
            end else begin
                check("hold_stable", 32'({fp_adr, fp_data}), 32'({snap_adr, snap_data}));
            end
            stab_cnt--;
        end
        if (fp_write && !prev_write) begin
            wr_adr_q.push_back(fp_adr);
            wr_data_q.push_back(fp_data);
            wr_width = 1;
        end else if (fp_write) begin
            wr_width++;
        end else if (prev_write) begin
            check("wr_width", 32'(wr_width), 32'(WR_CYCLES));
        end
        prev_write = fp_write;
        if (fp_clear && !prev_clear) begin
            clr_width = 1;
        end else if (fp_clear) begin
            clr_width++;
        end else if (prev_clear) begin
            check("clr_width", 32'(clr_width), 32'(CLR_CYCLES));
        end
        prev_clear = fp_clear;
        if (run_req) run_cnt++;
    endtask

    // mode 0: data 0,1,2.. with in_valid held; mode 1: random data, random in_valid, start spam.
    // abort_after >= 0 cancels once that many bytes are written and the loader waits again.
    task automatic do_load(input int mode, input int abort_after);
        int  budget;
        bit  aborted;
        mon_clear();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_clear", 32'({done, fp_clear, busy, fp_prog}), 32'(4'b0111));
        budget  = 0;
        aborted = 1'b0;
        while (run_cnt == 0 && budget < 2000 && !aborted) begin
            if (abort_after >= 0 && acc_q.size() == abort_after && in_ready) begin
                abort    = 1'b1;
                in_valid = 1'b1;
                in_data  = 8'hEE;
                tick();
                abort    = 1'b0;
                in_valid = 1'b0;
                check("abort_outs", 32'(outs()), 32'd0);
                aborted = 1'b1;
            end else begin
                in_valid = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
                in_data  = (mode == 0) ? DATA_W'(acc_q.size()) : DATA_W'($urandom);
                start    = (mode == 1) && ($urandom_range(0, 7) == 0);
                tick();
                budget++;
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        if (abort_after >= 0) begin
            check("abort_seen", 32'(aborted), 32'd1);
            check("abort_wr_count", 32'(wr_adr_q.size()), 32'(abort_after));
            check("abort_run", 32'(run_cnt), 32'd0);
            check("abort_idle", 32'({busy, fp_prog, done}), 32'd0);
        end else begin
            check("run_once", 32'(run_cnt), 32'd1);
            check("idle_after", 32'({busy, fp_prog, done}), 32'(3'b001));
            check("acc_count", 32'(acc_q.size()), 32'(DEPTH));
        end
        check("wr_count_vs_acc", 32'(wr_adr_q.size()), 32'(acc_q.size()));
        for (int i = 0; i < wr_adr_q.size() && i < acc_q.size(); i++) begin
            check($sformatf("wr%0d", i), 32'({wr_adr_q[i], wr_data_q[i]}),
                  32'({ADDR_W'(i), acc_q[i]}));
            if (mode == 0) check($sformatf("seq_data%0d", i), 32'(wr_data_q[i]), 32'(i));
        end
    endtask

    initial begin
        int n;
        // Opening of a load from reset, then a cancel and an ignored start+abort.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, {7'b1011000, 4'd0, 8'h00}};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, {7'b1011000, 4'd0, 8'h00}};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, {7'b1101000, 4'd0, 8'h00}};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 8'hA5, {7'b1001000, 4'd0, 8'hA5}};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'h3C, {7'b1001100, 4'd0, 8'hA5}};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h3C, {7'b1001100, 4'd0, 8'hA5}};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, {7'b1001000, 4'd0, 8'hA5}};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, {7'b1101000, 4'd1, 8'hA5}};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, {7'b1101000, 4'd1, 8'hA5}};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 8'h77, {7'b0000000, 4'd0, 8'h00}};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 8'h00, {7'b0000000, 4'd0, 8'h00}};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h00, {7'b0000000, 4'd0, 8'h00}};

        mon_clear();
        #12;
        check("reset_state", 32'(outs()), 32'd0);
        @(negedge sysclk);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            start    = vecs[i].start;
            abort    = vecs[i].abort;
            in_valid = vecs[i].in_valid;
            in_data  = vecs[i].in_data;
            tick();
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;

        // Full sequential load, randomized backpressure loads, then a cancel after 5 bytes.
        do_load(0, -1);
        for (int r = 0; r < 3; r++) do_load(1, -1);
        do_load(0, 5);

        // Reset pulled mid-strobe must drop fp_write without waiting for an edge.
        mon_clear();
        start = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        n = 0;
        while (!fp_write && n < 50) begin
            tick();
            n++;
        end
        check("reached_strobe", 32'(fp_write), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", 32'(outs()), 32'd0);
        in_valid = 1'b0;
        @(negedge sysclk);
        reset_n = 1'b1;
        mon_clear();
        tick();
        check("post_reset_idle", 32'(outs()), 32'd0);

        // Loader must be fully usable again after the interrupted load.
        do_load(1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
